// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, START/DATA/PARITY/STOP FSM, one-cycle result pulses.
// Define UART_RX_MAJORITY_VOTE_EN for a 2-of-3 vote around each bit centre instead of a single sample.
module uart_rx #(
    parameter int Data_WD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [5:0]         Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [Data_WD-1:0] P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err
);

    localparam int BW = $clog2(Data_WD + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_q;
    logic               sync1_q;
    logic               rx_s_q;
    logic [5:0]         pre_q;
    logic               par_en_q;
    logic               par_typ_q;
    logic [5:0]         edge_q;
    logic [BW-1:0]      bit_q;
    logic [Data_WD-1:0] shift_q;
    logic               par_bad_q;
    logic               stop_bad_q;

    logic [5:0]         pre_d;
    logic [5:0]         half;
    logic               wrap;
    logic               commit;
    logic               bit_val;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            rx_s_q  <= sync1_q;
        end
    end

    always_comb begin
        pre_d = 6'd8;
        if (Prescale == 6'd8 || Prescale == 6'd16 || Prescale == 6'd32)
            pre_d = Prescale;
    end

    assign half = {1'b0, pre_q[5:1]};
    assign wrap = (edge_q == pre_q - 6'd1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [2:0] vote_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vote_q <= '1;
        end else if (edge_q == half - 6'd1 || edge_q == half || edge_q == half + 6'd1) begin
            vote_q <= {vote_q[1:0], rx_s_q};
        end
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
    assign commit  = (edge_q == half + 6'd2);
`else
    logic sample_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sample_q <= 1'b1;
        end else if (edge_q == half) begin
            sample_q <= rx_s_q;
        end
    end

    assign bit_val = sample_q;
    assign commit  = (edge_q == half + 6'd1);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            pre_q      <= 6'd8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            edge_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state_q != IDLE)
                edge_q <= wrap ? 6'd0 : edge_q + 6'd1;

            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q    <= START;
                        edge_q     <= '0;
                        bit_q      <= '0;
                        pre_q      <= pre_d;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_bad_q  <= 1'b0;
                        stop_bad_q <= 1'b0;
                    end
                end
                START: begin
                    if (commit && bit_val)
                        state_q <= IDLE;
                    else if (wrap)
                        state_q <= DATA;
                end
                DATA: begin
                    if (commit)
                        shift_q <= {bit_val, shift_q[Data_WD-1:1]};
                    if (wrap) begin
                        if (bit_q == BW'(Data_WD - 1)) begin
                            bit_q   <= '0;
                            state_q <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    // Mismatch against XOR(data) for even, ~XOR(data) for odd.
                    if (commit)
                        par_bad_q <= bit_val ^ (^shift_q) ^ par_typ_q;
                    if (wrap)
                        state_q <= STOP;
                end
                STOP: begin
                    if (commit)
                        stop_bad_q <= ~bit_val;
                    if (wrap) begin
                        state_q <= IDLE;
                        if (stop_bad_q) begin
                            stp_err <= 1'b1;
                        end else if (par_bad_q) begin
                            par_err <= 1'b1;
                        end else begin
                            data_valid <= 1'b1;
                            P_DATA     <= shift_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
